t07_wb_fifo_sub: RTL
====================

T07_WB_FIFO_SUB -- requirements
Module: t07_wb_fifo_sub

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO (power of two, 2..16).
REQ-002 Parameter WIDTH, default 32, data width of both FIFOs and the bus.
REQ-003 wb_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write-enable from the decoder.
REQ-006 wbs_adr_i  in  32  byte address; only [3:2] decoded (base match done upstream).
REQ-007 wbs_sel_i  in  4  byte selects; honoured only for CTRL and IRQ, ignored for DATA.
REQ-008 wbs_dat_i  in  32  write data.
REQ-009 wbs_ack_o  out  1  transfer acknowledge.
REQ-010 wbs_dat_o  out  32  read data, valid while wbs_ack_o=1.
REQ-011 dev_rx_data_i  in  WIDTH, dev_rx_valid_i  in  1, dev_rx_ready_o  out  1  device-side push into RX FIFO.
REQ-012 dev_tx_data_o  out  WIDTH, dev_tx_valid_o  out  1, dev_tx_ready_i  in  1  device-side pop from TX FIFO.
REQ-013 irq_o  out  1  RX threshold interrupt.

Function
REQ-014 Register map (adr[3:2]): 0=DATA, 1=STATUS, 2=CTRL, 3=IRQ.
REQ-015 Bus FSM has states IDLE and ACK; IDLE->ACK when cyc&stb; ACK->IDLE unconditionally.
REQ-016 On the IDLE->ACK edge the access commits: push/pop/register write performed; read data registered into wbs_dat_o.
REQ-017 wbs_ack_o=1 only in ACK, exactly one cycle per access; latency 1 wait state; no new access is sampled in ACK.
REQ-018 wbs_dat_o=0 outside ACK and for every write access.
REQ-019 DATA read pops RX head; RX empty -> returns 0, no pop, sets sticky rx_udf.
REQ-020 DATA write pushes wbs_dat_i into TX; TX full -> data dropped, sets sticky tx_ovf.
REQ-021 STATUS read: [4:0] rx_count, [9:5] tx_count, [10] rx_empty, [11] rx_full, [12] tx_empty, [13] tx_full, [14] tx_ovf, [15] rx_udf, rest 0; STATUS write ignored, still acked.
REQ-022 CTRL write with sel[0]: bit0 clears RX, bit1 clears TX, bit2 clears both stickies; self-clearing; reads return 0.
REQ-023 IRQ write with sel[0] loads thresh=dat[4:0]; read returns thresh zero-extended.
REQ-024 irq_o = (thresh!=0) && (rx_count>=thresh), registered (one cycle after count change).
REQ-025 dev_rx_ready_o = !rx_full; push when dev_rx_valid_i&&dev_rx_ready_o.
REQ-026 dev_tx_valid_o = !tx_empty; dev_tx_data_o = TX head; pop when dev_tx_valid_o&&dev_tx_ready_i.
REQ-027 Counts 0..DEPTH; pointers wrap modulo DEPTH; full=(count==DEPTH), empty=(count==0).
REQ-028 Simultaneous push and pop on one FIFO: both occur, count unchanged; full RX with same-cycle bus pop still refuses device push (ready from registered count).
REQ-029 No bypass: a word pushed into an empty FIFO is poppable next cycle at earliest.
REQ-030 CTRL clear beats same-cycle push/pop on that FIFO: count=0, pointers=0, pushed word lost.
REQ-031 Sticky set and clear in same commit: clear wins.

Reset
REQ-032 wb_rst_i=1 at a clock edge: FSM=IDLE, wbs_ack_o=0, wbs_dat_o=0, both FIFOs empty, pointers 0, stickies 0, thresh=1, irq_o=0, dev_rx_ready_o=1, dev_tx_valid_o=0.
REQ-033 Reset during ACK aborts the ack (wbs_ack_o=0 next cycle); committed effects are discarded by the FIFO clear.
REQ-034 FIFO storage contents need not reset.

Verification
REQ-035 Device pushes 0xA5A5_0001..0xA5A5_0003; three DATA reads -> same values in order, each ack exactly 1 cycle after stb; fourth read -> 0, STATUS[15]=1.
REQ-036 Nine DATA writes (DEPTH=8) with dev_tx_ready_i=0 -> tx_count=8, tx_full=1, tx_ovf=1; release ready -> 8 words out in order, ninth absent.
REQ-037 RX full, dev_rx_valid_i=1, bus pops once -> ready stays 0 in commit cycle, rises next cycle, count returns to 8 after push.
REQ-038 thresh=3; push 3 words -> irq_o rises the cycle after third push; one pop -> irq_o falls; thresh=0 -> irq_o never asserts.
REQ-039 CTRL write 0x7 same cycle as device push -> rx_count=0, tx_count=0, stickies 0.
REQ-040 Assert wb_rst_i in ACK with 4 words queued -> ack low next cycle, STATUS reads 0x0000_1400.

Source files
------------

// File: rtl/t07_wb_fifo_sub_if.sv
// rtl/t07_wb_fifo_sub_if.sv - Wishbone classic slave bus bundle for the FIFO subsystem
interface t07_wb_fifo_sub_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/t07_wb_fifo_sub.sv
// rtl/t07_wb_fifo_sub.sv - Wishbone slave with RX/TX FIFOs, status, control and RX threshold irq
module t07_wb_fifo_sub #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    t07_wb_fifo_sub_if.slave        wb,
    input  logic [WIDTH-1:0]        dev_rx_data_i,
    input  logic                    dev_rx_valid_i,
    output logic                    dev_rx_ready_o,
    output logic [WIDTH-1:0]        dev_tx_data_o,
    output logic                    dev_tx_valid_o,
    input  logic                    dev_tx_ready_i,
    output logic                    irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ACK} busState_t;
    busState_t state, stateNext;

    logic [WIDTH-1:0] rxMem [DEPTH];
    logic [WIDTH-1:0] txMem [DEPTH];
    logic [AW-1:0]    rxWrPtr, rxRdPtr, txWrPtr, txRdPtr;
    logic [CW-1:0]    rxCount, txCount;
    logic             rxEmpty, rxFull, txEmpty, txFull;
    logic             rxPush, rxPop, txPush, txPop;
    logic             txOvf, rxUdf;
    logic [4:0]       thresh;
    logic [31:0]      datReg, rdData, statusWord;
    logic [1:0]       regSel;
    logic             commit, dataRd, dataWr, ctrlWr, irqWr;
    logic             clrRx, clrTx, clrSticky;
    logic             unusedBits;

    assign unusedBits = &{1'b0, wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1]};

    // An access commits only on the IDLE->ACK edge; nothing is sampled while in ACK.
    assign commit = (state == IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i;
    assign regSel = wb.wbs_adr_i[3:2];
    assign dataRd = commit && !wb.wbs_we_i && (regSel == 2'd0);
    assign dataWr = commit &&  wb.wbs_we_i && (regSel == 2'd0);
    assign ctrlWr = commit &&  wb.wbs_we_i && (regSel == 2'd2) && wb.wbs_sel_i[0];
    assign irqWr  = commit &&  wb.wbs_we_i && (regSel == 2'd3) && wb.wbs_sel_i[0];

    assign clrRx     = ctrlWr && wb.wbs_dat_i[0];
    assign clrTx     = ctrlWr && wb.wbs_dat_i[1];
    assign clrSticky = ctrlWr && wb.wbs_dat_i[2];

    assign rxEmpty = (rxCount == '0);
    assign rxFull  = (rxCount == CW'(DEPTH));
    assign txEmpty = (txCount == '0);
    assign txFull  = (txCount == CW'(DEPTH));

    // Flow control looks only at registered counts, so a same-cycle pop never frees a slot early.
    assign rxPush = dev_rx_valid_i && !rxFull;
    assign rxPop  = dataRd && !rxEmpty;
    assign txPush = dataWr && !txFull;
    assign txPop  = !txEmpty && dev_tx_ready_i;

    assign dev_rx_ready_o = !rxFull;
    assign dev_tx_valid_o = !txEmpty;
    assign dev_tx_data_o  = txMem[txRdPtr];

    assign statusWord = {16'd0, rxUdf, txOvf, txFull, txEmpty, rxFull, rxEmpty,
                         5'(txCount), 5'(rxCount)};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (wb.wbs_cyc_i && wb.wbs_stb_i) stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        wb.wbs_ack_o = (state == ACK);
        wb.wbs_dat_o = (state == ACK) ? datReg : 32'd0;
    end

    always_comb begin
        rdData = 32'd0;
        if (!wb.wbs_we_i) begin
            case (regSel)
                2'd0:    if (!rxEmpty) rdData = 32'(rxMem[rxRdPtr]);
                2'd1:    rdData = statusWord;
                2'd3:    rdData = {27'd0, thresh};
                default: rdData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)    datReg <= 32'd0;
        else if (commit) datReg <= rdData;
    end

    // Storage is never reset; pointers and counts define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (rxPush) rxMem[rxWrPtr] <= dev_rx_data_i;
        if (txPush) txMem[txWrPtr] <= WIDTH'(wb.wbs_dat_i);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clrRx) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
        end else begin
            if (rxPush) rxWrPtr <= rxWrPtr + AW'(1);
            if (rxPop)  rxRdPtr <= rxRdPtr + AW'(1);
            rxCount <= rxCount + CW'(rxPush) - CW'(rxPop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clrTx) begin
            txWrPtr <= '0;
            txRdPtr <= '0;
            txCount <= '0;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + AW'(1);
            if (txPop)  txRdPtr <= txRdPtr + AW'(1);
            txCount <= txCount + CW'(txPush) - CW'(txPop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clrSticky) begin
            txOvf <= 1'b0;
            rxUdf <= 1'b0;
        end else begin
            if (dataWr && txFull)  txOvf <= 1'b1;
            if (dataRd && rxEmpty) rxUdf <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)   thresh <= 5'd1;
        else if (irqWr) thresh <= wb.wbs_dat_i[4:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_o <= 1'b0;
        else          irq_o <= (thresh != 5'd0) && (5'(rxCount) >= thresh);
    end
endmodule
